// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 8-entry register file.
package reg_file_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_COUNT  = 8;
  localparam int DATA_W     = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_read_mux.sv
// WIDTH-wide 8:1 word select, one 1-bit 8:1 mux cell per data bit.
import reg_file_pkg::*;

module mux8_cell (
  input  logic [REG_COUNT-1:0] d,
  input  reg_addr_t            sel,
  output logic                 y
);
  assign y = d[sel];
endmodule

module reg_read_mux #(
  parameter int WIDTH = DATA_W
) (
  input  logic [REG_COUNT-1:0][WIDTH-1:0] words,
  input  reg_addr_t                       sel,
  output logic [WIDTH-1:0]                word
);
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [REG_COUNT-1:0] bit_slice;
      // Gather bit gi of every register into one cell input vector.
      for (genvar gj = 0; gj < REG_COUNT; gj++) begin : g_word
        assign bit_slice[gj] = words[gj][gi];
      end
      mux8_cell u_cell (
        .d   (bit_slice),
        .sel (sel),
        .y   (word[gi])
      );
    end
  endgenerate
endmodule

// File: rtl/reg_file8.sv
// 8 x WIDTH register file: one write port, two registered read ports with valid flags.
// Optional same-cycle write-to-read bypass: define REG_FILE8_WRITE_BYPASS_EN.
import reg_file_pkg::*;

module reg_file8 #(
  parameter int               WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  reg_addr_t        waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  reg_addr_t        raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  reg_addr_t        raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b
);
  logic [REG_COUNT-1:0][WIDTH-1:0] regs_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_reg[i] <= RST_VAL;
    end else if (we) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // Index 0 is port A, index 1 is port B.
  logic      [1:0]       port_re;
  reg_addr_t             port_addr [2];
  logic      [WIDTH-1:0] rdata_reg [2];
  logic      [1:0]       rvalid_reg;

  assign port_re      = {re_b, re_a};
  assign port_addr[0] = raddr_a;
  assign port_addr[1] = raddr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] mux_word;
      logic [WIDTH-1:0] rdata_next;

      reg_read_mux #(.WIDTH(WIDTH)) u_mux (
        .words (regs_reg),
        .sel   (port_addr[gi]),
        .word  (mux_word)
      );

`ifdef REG_FILE8_WRITE_BYPASS_EN
      assign rdata_next = (we && (waddr == port_addr[gi])) ? wdata : mux_word;
`else
      assign rdata_next = mux_word;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg[gi]  <= '0;
          rvalid_reg[gi] <= 1'b0;
        end else begin
          rvalid_reg[gi] <= port_re[gi];
          if (port_re[gi]) rdata_reg[gi] <= rdata_next;
        end
      end
    end
  endgenerate

  assign rdata_a  = rdata_reg[0];
  assign rdata_b  = rdata_reg[1];
  assign rvalid_a = rvalid_reg[0];
  assign rvalid_b = rvalid_reg[1];
endmodule

// File: tb/tb_reg_file8.sv
// Directed and random-soak bench for reg_file8 (either build of REG_FILE8_WRITE_BYPASS_EN).
`timescale 1ns/1ps
module tb_reg_file8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        re_a, re_b;
  logic [2:0]  raddr_a, raddr_b;
  logic [15:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef REG_FILE8_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file8 dut (
    .clk(clk), .rst_n(rst_n),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are applied 1 ns after a rising edge; step() advances to 1 ns after the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; re_a = 0; re_b = 0;
  endtask

  logic [15:0] mem [8];
  logic [15:0] ma, mb, nxa, nxb;
  logic        mva, mvb;

  initial begin
    rst_n = 0; idle(); waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
    step(); step();
    rst_n = 1;
    step();

    // Load reg 1 and read it so outputs are nonzero before reset.
    we = 1; waddr = 1; wdata = 16'h7777; step();
    idle(); re_a = 1; re_b = 1; raddr_a = 1; raddr_b = 1; step();
    check("pre_rst_rdata_a", rdata_a, 16'h7777);
    #3 rst_n = 0;
    #1;
    check("async_rst_rdata_a", rdata_a, 16'h0);
    check("async_rst_rdata_b", rdata_b, 16'h0);
    check("async_rst_rvalid", {14'b0, rvalid_a, rvalid_b}, 16'h0);
    idle(); step(); step();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      re_a = 1; re_b = 1; raddr_a = 3'(i); raddr_b = 3'(7 - i); step();
      check($sformatf("rst_read_a%0d", i), rdata_a, 16'h0);
      check($sformatf("rst_read_b%0d", 7 - i), rdata_b, 16'h0);
    end
    idle();

    // Write/readback, A=i and B=7-i.
    for (int i = 0; i < 8; i++) begin
      we = 1; waddr = 3'(i); wdata = 16'hA5A0 + 16'(i); step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      re_a = 1; re_b = 1; raddr_a = 3'(i); raddr_b = 3'(7 - i); step();
      check($sformatf("wr_rd_a%0d", i), rdata_a, 16'hA5A0 + 16'(i));
      check($sformatf("wr_rd_b%0d", i), rdata_b, 16'hA5A7 - 16'(i));
      check($sformatf("wr_rd_valid%0d", i), {14'b0, rvalid_a, rvalid_b}, 16'h3);
    end
    idle(); step();
    check("valid_drop", {14'b0, rvalid_a, rvalid_b}, 16'h0);

    // Hold: rdata_a keeps 1234 while re_a is low.
    we = 1; waddr = 2; wdata = 16'h1234; step();
    idle(); re_a = 1; raddr_a = 2; step();
    check("hold_first", rdata_a, 16'h1234);
    re_a = 0; raddr_a = 6;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_data%0d", i), rdata_a, 16'h1234);
      check($sformatf("hold_valid%0d", i), {15'b0, rvalid_a}, 16'h0);
    end

    // Same-cycle collision on reg 3.
    we = 1; waddr = 3; wdata = 16'h0F0F; step();
    we = 1; waddr = 3; wdata = 16'hBEEF; re_a = 1; raddr_a = 3; step();
    check("collision", rdata_a, BYPASS ? 16'hBEEF : 16'h0F0F);
    idle(); re_a = 1; raddr_a = 3; step();
    check("collision_after", rdata_a, 16'hBEEF);
    idle();

    // Reset mid-write: reset lands before the edge that would commit.
    we = 1; waddr = 5; wdata = 16'hFFFF;
    #3 rst_n = 0;
    step();
    idle(); step();
    rst_n = 1;
    re_a = 1; re_b = 1; raddr_a = 5; raddr_b = 5; step();
    check("rst_mid_write_a", rdata_a, 16'h0);
    check("rst_mid_write_b", rdata_b, 16'h0);
    idle();

    // Random soak against a reference model; all registers are zero here.
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    ma = 16'h0; mb = 16'h0;
    for (int c = 0; c < 500; c++) begin
      we = 1'($urandom); waddr = 3'($urandom); wdata = 16'($urandom);
      re_a = 1'($urandom); raddr_a = 3'($urandom);
      re_b = 1'($urandom); raddr_b = 3'($urandom);
      if (c % 7 == 0) raddr_a = waddr;
      nxa = (BYPASS && we && waddr == raddr_a) ? wdata : mem[raddr_a];
      nxb = (BYPASS && we && waddr == raddr_b) ? wdata : mem[raddr_b];
      if (re_a) ma = nxa;
      if (re_b) mb = nxb;
      mva = re_a; mvb = re_b;
      if (we) mem[waddr] = wdata;
      step();
      check($sformatf("soak%0d_rdata_a", c), rdata_a, ma);
      check($sformatf("soak%0d_rdata_b", c), rdata_b, mb);
      check($sformatf("soak%0d_rvalid", c), {14'b0, rvalid_a, rvalid_b}, {14'b0, mva, mvb});
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
